hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It works alongside the forwarding unit and covers the cases forwarding cannot resolve:
- load-use hazards;
- branch operands in ID that depend on in-flight results;
- structural/data hazards on the multi-cycle multiply/divide unit (HI/LO).

It drives the stall and flush controls for IF/ID/EX. It also sequences the mul/div unit through a busy FSM with a cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_if.sv | 27 ++
 rtl/hazard_ctrl_md_seq.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 64 ++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: mul/div FSM encoding,
// stall polarity constants and the ID/EX/MEM request bundle.
package hazard_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic STALL    = 1'b1;
  localparam logic NO_STALL = 1'b0;

  typedef struct packed {
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic [4:0] WriteReg_EX;
    logic [4:0] WriteReg_MEM;
    logic       regWr_EX;
    logic       memToReg_EX;
    logic       memToReg_MEM;
    logic       branch_ID;
    logic       md_start_ID;
    logic       md_is_div_ID;
    logic       mfhilo_ID;
  } hz_req_t;

  // $zero never creates a dependency
  function automatic logic src_match(input logic [4:0] d, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (d != 5'd0) && ((d == rs) || (d == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline register fields in, stall/flush and
// mul/div sequencing out.
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  import hazard_ctrl_pkg::*;

  hz_req_t             req;
  logic                stallF;
  logic                stallD;
  logic                flushE;
  logic                md_start;
  logic                md_busy;
  logic                md_done;
  logic [PERF_W-1:0]   stall_cnt;

  modport master (
    output req,
    input  stallF, stallD, flushE, md_start, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  req,
    output stallF, stallD, flushE, md_start, md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Mul/div sequencer: gates the launch pulse, then counts the unit's latency
// down and pulses md_done in the cycle HI/LO is written.
module md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_ID,
  input  logic md_is_div_ID,
  input  logic lwstall,
  input  logic brstall,
  output logic md_start,
  output logic md_busy,
  output logic md_done
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // rst gates every output so an in-flight op is dropped without a done pulse
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md_start_ID && !lwstall && !brstall && !rst) begin
          md_start = 1'b1;
          state_d  = MD_BUSY;
          cnt_d    = md_is_div_ID ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end
      end
      MD_BUSY: begin
        md_busy = !rst;
        if (cnt_q == '0) begin
          md_done = !rst;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use, branch-in-ID and HI/LO stalls for the 5-stage
// core, mul/div sequencing, and a saturating stalled-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  hz_req_t           req;
  logic              lwstall, brstall, mdstall, stall;
  logic              md_start, md_busy, md_done;
  logic [PERF_W-1:0] perf_q;

  assign req = hz.req;

  assign lwstall = req.memToReg_EX & req.regWr_EX &
                   src_match(req.WriteReg_EX, req.rs_ID, req.rt_ID);

  // branch compares in ID: EX results and MEM loads are not forwardable yet
  assign brstall = req.branch_ID &
                   ((req.regWr_EX & src_match(req.WriteReg_EX, req.rs_ID, req.rt_ID)) |
                    (req.memToReg_MEM & src_match(req.WriteReg_MEM, req.rs_ID, req.rt_ID)));

  assign mdstall = md_busy & (req.mfhilo_ID | req.md_start_ID);

  assign stall = (rst == 1'b1) ? NO_STALL : ((lwstall | brstall | mdstall) ? STALL : NO_STALL);

  md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_seq (
    .clk          (clk),
    .rst          (rst),
    .md_start_ID  (req.md_start_ID),
    .md_is_div_ID (req.md_is_div_ID),
    .lwstall      (lwstall),
    .brstall      (brstall),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_done      (md_done)
  );

  always_ff @(posedge clk) begin
    if (rst)                           perf_q <= '0;
    else if (stall && (perf_q != '1))  perf_q <= perf_q + PERF_W'(1);
  end

  assign hz.stallF    = stall;
  assign hz.stallD    = stall;
  assign hz.flushE    = stall;
  assign hz.md_start  = md_start;
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = md_done;
  assign hz.stall_cnt = rst ? '0 : perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations (default, and N=1 mult / 3-cycle
// div / 4-bit perf counter) driven in lockstep against a cycle-count model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  hz_req_t req;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(32)) if0 ();
  hazard_ctrl_if #(.PERF_W(4))  if1 ();
  assign if0.req = req;
  assign if1.req = req;

  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(32)) dut0 (
    .clk(clk), .rst(rst), .hz(if0.slave));
  hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(3), .CNT_W(2), .PERF_W(4)) dut1 (
    .clk(clk), .rst(rst), .hz(if1.slave));

  logic [37:0] act0, exp0;
  logic [9:0]  act1, exp1;
  assign act0 = {if0.stallF, if0.stallD, if0.flushE, if0.md_start, if0.md_busy, if0.md_done, if0.stall_cnt};
  assign act1 = {if1.stallF, if1.stallD, if1.flushE, if1.md_start, if1.md_busy, if1.md_done, if1.stall_cnt};

  int compared = 0;
  int mismatched = 0;

  // model: busy cycles remaining per DUT and stalled-cycle count
  int     bl[2];
  longint sc[2];
  int     mul_n[2] = '{4, 1};
  int     div_n[2] = '{32, 3};
  longint smax[2]  = '{64'hFFFF_FFFF, 64'd15};
  bit     m_start[2], m_stall[2];

  function automatic bit hit(input logic [4:0] d);
    return (d != 5'd0) && (d == req.rs_ID || d == req.rt_ID);
  endfunction

  task automatic model_eval();
    bit lw, br, busy, done, st, go;
    lw = req.memToReg_EX && req.regWr_EX && hit(req.WriteReg_EX);
    br = req.branch_ID && ((req.regWr_EX && hit(req.WriteReg_EX)) ||
                           (req.memToReg_MEM && hit(req.WriteReg_MEM)));
    for (int k = 0; k < 2; k++) begin
      busy = bl[k] > 0;
      done = bl[k] == 1;
      st   = lw || br || (busy && (req.mfhilo_ID || req.md_start_ID));
      go   = req.md_start_ID && !busy && !lw && !br;
      if (rst) begin busy = 0; done = 0; st = 0; go = 0; end
      m_start[k] = go;
      m_stall[k] = st;
      if (k == 0) exp0 = {st, st, st, go, busy, done, rst ? 32'd0 : sc[0][31:0]};
      else        exp1 = {st, st, st, go, busy, done, rst ? 4'd0 : sc[1][3:0]};
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        bl[k] = 0;
        sc[k] = 0;
      end else begin
        if (m_start[k])     bl[k] = req.md_is_div_ID ? div_n[k] : mul_n[k];
        else if (bl[k] > 0) bl[k] = bl[k] - 1;
        if (m_stall[k] && sc[k] < smax[k]) sc[k] = sc[k] + 1;
      end
    end
    #1;
  endtask

  task automatic rand_req(input bit md);
    req.rs_ID        = 5'($urandom_range(0, 3));
    req.rt_ID        = 5'($urandom_range(0, 3));
    req.WriteReg_EX  = 5'($urandom_range(0, 3));
    req.WriteReg_MEM = 5'($urandom_range(0, 3));
    req.regWr_EX     = 1'($urandom_range(0, 1));
    req.memToReg_EX  = 1'($urandom_range(0, 1));
    req.memToReg_MEM = 1'($urandom_range(0, 1));
    req.branch_ID    = 1'($urandom_range(0, 1));
    req.md_start_ID  = md ? 1'($urandom_range(0, 1)) : 1'b0;
    req.md_is_div_ID = md ? 1'($urandom_range(0, 1)) : 1'b0;
    req.mfhilo_ID    = md ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rand_req(1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_req(1'b1);
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || act0 !== '0 || act1 !== '0) begin
        mismatched++;
        $display("FAIL reset c%0d dut0 got=%h want=%h dut1 got=%h want=%h", i, act0, exp0, act1, exp1);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    logic [4:0] wr[2] = '{5'd5, 5'd0};
    logic [2:0] want[2] = '{3'b111, 3'b000};
    for (int i = 0; i < 2; i++) begin
      req = '0;
      req.memToReg_EX = 1'b1; req.regWr_EX = 1'b1; req.rs_ID = 5'd5; req.rt_ID = 5'd9;
      req.WriteReg_EX = wr[i];
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || {if0.stallF, if0.stallD, if0.flushE} !== want[i]) begin
        mismatched++;
        $display("FAIL load_use wr=%0d dut0 got=%h want=%h dut1 got=%h want=%h", wr[i], act0, exp0, act1, exp1);
      end
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      rand_req(1'b0);
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1) begin
        mismatched++;
        $display("FAIL load_use_rand c%0d dut0 got=%h want=%h dut1 got=%h want=%h", i, act0, exp0, act1, exp1);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    bit want[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      req = '0;
      req.branch_ID = 1'b1; req.rt_ID = 5'd8; req.rs_ID = 5'd2;
      if (i == 0) begin req.regWr_EX = 1'b1; req.WriteReg_EX = 5'd8; end
      else begin req.WriteReg_MEM = 5'd8; req.memToReg_MEM = (i == 1); end
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || if0.stallF !== want[i]) begin
        mismatched++;
        $display("FAIL branch case%0d dut0 got=%h want=%h dut1 got=%h want=%h", i, act0, exp0, act1, exp1);
      end
      tick();
    end
    for (int i = 0; i < 30; i++) begin
      rand_req(1'b0);
      req.branch_ID = 1'b1;
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1) begin
        mismatched++;
        $display("FAIL branch_rand c%0d dut0 got=%h want=%h dut1 got=%h want=%h", i, act0, exp0, act1, exp1);
      end
      tick();
    end
  endtask

  task automatic test_multiply();
    bit wb, wd, ws;
    for (int c = 0; c <= 6; c++) begin
      req = '0;
      req.md_start_ID = (c == 0);
      req.mfhilo_ID   = (c >= 1 && c <= 5);
      wb = (c >= 1 && c <= 4);
      wd = (c == 4);
      ws = (c >= 1 && c <= 4);
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || if0.md_busy !== wb || if0.md_done !== wd ||
          if0.stallF !== ws || if0.md_start !== (c == 0)) begin
        mismatched++;
        $display("FAIL multiply c%0d dut0 got=%h want=%h dut1 got=%h want=%h", c, act0, exp0, act1, exp1);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit launched = 1'b0;
    for (int c = 0; c <= 38; c++) begin
      req = '0;
      req.md_start_ID  = (c == 0) || (c >= 1 && !launched);
      req.md_is_div_ID = (c == 0);
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || if0.stallF !== (c >= 1 && c <= 32) ||
          if0.md_done !== (c == 32 || c == 37) || if0.md_start !== (c == 0 || c == 33)) begin
        mismatched++;
        $display("FAIL back_to_back c%0d dut0 got=%h want=%h dut1 got=%h want=%h", c, act0, exp0, act1, exp1);
      end
      if (c >= 1 && m_start[0]) launched = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c <= 15; c++) begin
      req = '0;
      rst = (c == 10);
      req.md_start_ID  = (c == 0);
      req.md_is_div_ID = 1'b1;
      if (c == 10) begin
        req.memToReg_EX = 1'b1; req.regWr_EX = 1'b1; req.WriteReg_EX = 5'd3; req.rs_ID = 5'd3;
        req.md_start_ID = 1'b1; req.mfhilo_ID = 1'b1;
      end
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || (c >= 10 && act0 !== '0)) begin
        mismatched++;
        $display("FAIL reset_midop c%0d dut0 got=%h want=%h dut1 got=%h want=%h", c, act0, exp0, act1, exp1);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 20; c++) begin
      req = '0;
      req.memToReg_EX = 1'b1; req.regWr_EX = 1'b1; req.WriteReg_EX = 5'd7; req.rt_ID = 5'd7;
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1 || (c == 19 && if1.stall_cnt !== 4'hF)) begin
        mismatched++;
        $display("FAIL saturation c%0d dut0 got=%h want=%h dut1 got=%h want=%h", c, act0, exp0, act1, exp1);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_req(1'b1);
      rst = ($urandom_range(0, 49) == 0);
      settle();
      compared++;
      if (act0 !== exp0 || act1 !== exp1) begin
        mismatched++;
        $display("FAIL random c%0d rst=%0b dut0 got=%h want=%h dut1 got=%h want=%h", c, rst, act0, exp0, act1, exp1);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    bl  = '{0, 0};
    sc  = '{0, 0};
    test_reset();
    test_load_use();
    test_branch();
    test_multiply();
    test_back_to_back();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
